// File: rtl/reg_reader_pkg.sv
// Shared defaults and overflow-counter constants for the register change reader.
package reg_reader_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int OVF_W      = 8;

  typedef logic [OVF_W-1:0] ovf_t;

  localparam ovf_t OVF_MAX = {OVF_W{1'b1}};

  // Increment that sticks at OVF_MAX instead of wrapping.
  function automatic ovf_t ovf_sat_inc(input ovf_t val);
    return (val == OVF_MAX) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/reg_reader_fifo.sv
// Capture FIFO: register array with a combinational head read so a value pushed
// into an empty FIFO is visible the very next cycle.
module reg_reader_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_FULL);
  assign do_pop  = pop && !empty;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset) mem[wr_ptr_reg] <= wr_data;
  end

  // Stale storage is masked so an empty FIFO always presents zero.
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/reg_change_reader.sv
// Captures changes of an upstream register into a FIFO for a downstream reader.
// Define REG_CHANGE_READER_OVF_EN to add the saturating ovf_cnt drop counter port.
module reg_change_reader
  import reg_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] reg_val,
  input  logic              sample_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              full
`ifdef REG_CHANGE_READER_OVF_EN
  ,
  output logic [OVF_W-1:0]  ovf_cnt
`endif
);

  logic [DATA_W-1:0] last_val_reg;
  logic              last_valid_reg;
  logic              capture;
  logic              pop;
  logic              push;
  logic              empty;

  assign capture   = sample_en && (!last_valid_reg || (reg_val != last_val_reg));
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = capture && (!full || pop);

  // The reference value advances on every capture, even ones that get dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_val_reg   <= '0;
      last_valid_reg <= 1'b0;
    end else if (capture) begin
      last_val_reg   <= reg_val;
      last_valid_reg <= 1'b1;
    end
  end

  reg_reader_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (reg_val),
    .rd_data (out_data),
    .full    (full),
    .empty   (empty)
  );

`ifdef REG_CHANGE_READER_OVF_EN
  logic drop;
  ovf_t ovf_cnt_reg;

  assign drop = capture && !push;

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_cnt_reg <= '0;
    end else if (drop) begin
      ovf_cnt_reg <= ovf_sat_inc(ovf_cnt_reg);
    end
  end

  assign ovf_cnt = ovf_cnt_reg;
`endif

endmodule

// File: tb/tb_reg_change_reader.sv
// Directed self-checking bench for reg_change_reader at DATA_W=8, DEPTH=4.
module tb_reg_change_reader;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] reg_val;
  logic       sample_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       full;
`ifdef REG_CHANGE_READER_OVF_EN
  logic [7:0] ovf_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  reg_change_reader dut (
    .clock     (clock),
    .reset     (reset),
    .reg_val   (reg_val),
    .sample_en (sample_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full)
`ifdef REG_CHANGE_READER_OVF_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_val(input logic [7:0] v);
    sample_en = 1'b1;
    reg_val   = v;
    step();
    sample_en = 1'b0;
  endtask

  // Pop the head, checking it against exp.
  task automatic pop_expect(input string name, input logic [7:0] exp);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp) begin
      fails++;
      $display("FAIL %s: out_valid=%b out_data=%02h, required valid=1 data=%02h", name, out_valid, out_data, exp);
    end else begin
      $display("pop %s: data=%02h", name, out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_en = 1'b1; reg_val = 8'h5A; out_ready = 1'b1;
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || full !== 1'b0 || out_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b full=%b data=%02h, required 0 0 00", out_valid, full, out_data);
    end
`ifdef REG_CHANGE_READER_OVF_EN
    checks++;
    if (ovf_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_ovf: ovf_cnt=%0d, required 0", ovf_cnt);
    end
`endif
    sample_en = 1'b0; out_ready = 1'b0;
    reset = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL after_reset_valid: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_zero_capture();
    push_val(8'h00);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h00) begin
      fails++;
      $display("FAIL zero_capture: valid=%b data=%02h, required 1 00", out_valid, out_data);
    end
    pop_expect("zero_drain", 8'h00);
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL zero_empty: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_dedup();
    push_val(8'h12);
    push_val(8'h12);
    push_val(8'h34);
    checks++;
    if (full !== 1'b0 || out_data !== 8'h12) begin
      fails++;
      $display("FAIL dedup_state: full=%b data=%02h, required 0 12", full, out_data);
    end
    step(); step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h12) begin
      fails++;
      $display("FAIL dedup_hold: valid=%b data=%02h, required 1 12", out_valid, out_data);
    end
    pop_expect("dedup_0", 8'h12);
    pop_expect("dedup_1", 8'h34);
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL dedup_count: out_valid=%b after two pops, required 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) push_val(8'(i));
    checks++;
    if (full !== 1'b1) begin
      fails++;
      $display("FAIL ovf_full: full=%b after four pushes, required 1", full);
    end
    push_val(8'h05);
`ifdef REG_CHANGE_READER_OVF_EN
    checks++;
    if (ovf_cnt !== 8'd1) begin
      fails++;
      $display("FAIL ovf_count: ovf_cnt=%0d, required 1", ovf_cnt);
    end
`endif
    for (int i = 1; i <= 4; i++) pop_expect("ovf_drain", 8'(i));
    checks++;
    if (out_valid !== 1'b0 || full !== 1'b0) begin
      fails++;
      $display("FAIL ovf_dropped: valid=%b full=%b, required 0 0", out_valid, full);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 4; i++) push_val(8'(i));
    out_ready = 1'b1;
    push_val(8'hAA);
    out_ready = 1'b0;
    checks++;
    if (full !== 1'b1 || out_data !== 8'h02) begin
      fails++;
      $display("FAIL pushpop_state: full=%b data=%02h, required 1 02", full, out_data);
    end
`ifdef REG_CHANGE_READER_OVF_EN
    checks++;
    if (ovf_cnt !== 8'd1) begin
      fails++;
      $display("FAIL pushpop_ovf: ovf_cnt=%0d, required 1", ovf_cnt);
    end
`endif
    pop_expect("pushpop_0", 8'h02);
    pop_expect("pushpop_1", 8'h03);
    pop_expect("pushpop_2", 8'h04);
    pop_expect("pushpop_3", 8'hAA);
  endtask

  task automatic test_reset_mid();
    push_val(8'h01);
    push_val(8'h02);
    push_val(8'h03);
    reset = 1'b1; out_ready = 1'b1; sample_en = 1'b1; reg_val = 8'h77;
    step();
    reset = 1'b0; out_ready = 1'b0; sample_en = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || full !== 1'b0 || out_data !== 8'h00) begin
      fails++;
      $display("FAIL midreset_flush: valid=%b full=%b data=%02h, required 0 0 00", out_valid, full, out_data);
    end
`ifdef REG_CHANGE_READER_OVF_EN
    checks++;
    if (ovf_cnt !== 8'd0) begin
      fails++;
      $display("FAIL midreset_ovf: ovf_cnt=%0d, required 0", ovf_cnt);
    end
`endif
    push_val(8'h03);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h03) begin
      fails++;
      $display("FAIL midreset_recapture: valid=%b data=%02h, required 1 03", out_valid, out_data);
    end
    pop_expect("midreset_drain", 8'h03);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) push_val(8'h40 + 8'(i));
    for (int i = 0; i < 300; i++) begin
      push_val((i % 2 == 0) ? 8'h10 : 8'h11);
`ifdef REG_CHANGE_READER_OVF_EN
      if (i == 253) begin
        checks++;
        if (ovf_cnt !== 8'd254) begin
          fails++;
          $display("FAIL sat_mid: ovf_cnt=%0d after 254 drops, required 254", ovf_cnt);
        end
      end
`endif
    end
`ifdef REG_CHANGE_READER_OVF_EN
    checks++;
    if (ovf_cnt !== 8'd255) begin
      fails++;
      $display("FAIL sat_final: ovf_cnt=%0d after 300 drops, required 255", ovf_cnt);
    end
`endif
    checks++;
    if (full !== 1'b1) begin
      fails++;
      $display("FAIL sat_full: full=%b, required 1", full);
    end
    for (int i = 0; i < 4; i++) pop_expect("sat_drain", 8'h40 + 8'(i));
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL sat_empty: out_valid=%b, required 0", out_valid);
    end
  endtask

  initial begin
    reset = 1'b1; reg_val = 8'h00; sample_en = 1'b0; out_ready = 1'b0;
    test_reset();
    test_zero_capture();
    test_dedup();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/reg_change_reader.md
REG_CHANGE_READER -- requirements
Module: reg_change_reader

Interface
REQ-001 Parameter DATA_W, default 8: width of the monitored register value and the output data.
REQ-002 Parameter DEPTH, default 4: capture FIFO entries; power of two, minimum 2.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reg_val  input  DATA_W  current value of the upstream prioritised-write register.
REQ-006 sample_en  input  1  enables change detection in this cycle.
REQ-007 out_data  output  DATA_W  FIFO head value.
REQ-008 out_valid  output  1  FIFO non-empty.
REQ-009 out_ready  input  1  downstream accepts out_data.
REQ-010 full  output  1  FIFO holds DEPTH entries.
REQ-011 ovf_cnt  output  8  count of dropped captures; present only with REG_CHANGE_READER_OVF_EN.

Function
REQ-012 Capture condition: sample_en high AND (last_valid low OR reg_val != last_val).
REQ-013 On capture: last_val <= reg_val; last_valid <= 1, whether or not the push succeeds.
REQ-014 A capture pushes reg_val when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-015 A capture that cannot push drops the value and is counted as an overflow.
REQ-016 Pop occurs when out_valid AND out_ready.
REQ-017 Simultaneous push and pop: count unchanged; head advances and the new value is written at the tail.
REQ-018 Latency: a value captured at edge N asserts out_valid and appears on out_data in the cycle after edge N when the FIFO was empty.
REQ-019 out_valid is derived from count != 0 with no combinational path from reg_val or sample_en.
REQ-020 While out_valid is high and out_ready is low, out_data and out_valid are held stable.
REQ-021 Read and write pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-022 full == (count == DEPTH).
REQ-023 With sample_en low, last_val and last_valid hold and no push occurs.

Reset
REQ-024 Reset clears count, both pointers, last_val (to 0), last_valid, and ovf_cnt to 0.
REQ-025 Outputs during and after reset: out_valid 0, full 0, out_data 0, ovf_cnt 0.
REQ-026 Reset asserted mid-operation discards all queued entries at that edge and takes priority over push and pop in the same cycle.
REQ-027 The first enabled sample after reset always captures, including a value of 0.

Configuration
REQ-028 Macro REG_CHANGE_READER_OVF_EN, when defined, adds the 8-bit ovf_cnt port and counter.
REQ-029 With the macro defined, ovf_cnt increments by 1 on each dropped capture and saturates at 255.
REQ-030 Without the macro, the port and counter are absent and drops are silent; all other behaviour is identical.

Structure
REQ-031 Package reg_reader_pkg holds the DATA_W and DEPTH defaults, OVF_W = 8, and the OVF_MAX constant.
REQ-032 Storage, pointers and count are implemented in sub-module reg_reader_fifo (push/pop/full/empty interface); change detection and the overflow counter are in the top level.

Verification
REQ-033 Reset, then sample_en=1 with reg_val=0x00 -> one entry; out_valid=1 the next cycle with out_data=0x00.
REQ-034 reg_val sequence 0x12,0x12,0x34 over three enabled cycles with out_ready=0 -> exactly two entries (0x12, 0x34); full=0 at DEPTH=4.
REQ-035 Five distinct values 0x01..0x05 with out_ready=0 -> full=1 after the fourth; 0x05 dropped; ovf_cnt=1 (macro on); drain yields 0x01..0x04 in order.
REQ-036 FIFO full, out_ready=1, and a new distinct value 0xAA in the same cycle -> 0x01 popped, 0xAA pushed, full stays 1, ovf_cnt unchanged.
REQ-037 With 3 entries queued, reset asserted for one cycle -> out_valid=0 next cycle; next enabled sample of the prior value 0x03 captures again.
REQ-038 300 forced drops (macro on) -> ovf_cnt saturates at 255; macro off -> build has no ovf_cnt port and FIFO behaviour is unchanged.
